// File: rtl/cae_line_buffer_pkg.sv
// Shared defaults and helpers for the CAE line buffer.
// Holds the default pixel width, window width and image size.
package cae_line_buffer_pkg;

    localparam int CAE_DATA_WIDTH = 8;
    localparam int CAE_INPUT_SIZE = 3;
    localparam int CAE_IMG_W      = 28;
    localparam int CAE_IMG_H      = 28;

    // Counter width able to hold 0..n-1, at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cae_line_mem.sv
// One image row of pixel storage, one read and one write per cycle.
// Ports: clk_i, we, addr, wr_data, rd_data (read-before-write, async read).
module cae_line_mem
    import cae_line_buffer_pkg::*;
#(
    parameter int DEPTH = CAE_IMG_W,
    parameter int WIDTH = CAE_DATA_WIDTH,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Combinational read returns the old word in the same cycle
    // the new word is written.
    assign rd_data = mem[addr];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/cae_line_buffer.sv
// Streaming 3-row window generator feeding the CAE conv operand.
// Ports: clk_i, rst (sync, active-low), in_* pixel handshake, win_* window handshake, frame_done.
module cae_line_buffer
    import cae_line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = CAE_DATA_WIDTH,
    parameter int KW         = CAE_INPUT_SIZE,
    parameter int IMG_W      = CAE_IMG_W,
    parameter int IMG_H      = CAE_IMG_H
) (
    input  logic                                 clk_i,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [2:0][KW-1:0][DATA_WIDTH-1:0]   win,
    output logic                                 frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    typedef logic [2:0][KW-1:0][DATA_WIDTH-1:0] win_t;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    win_t                  sr;
    win_t                  sr_next;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [DATA_WIDTH-1:0] lb2_rd;
    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  qualify;

    assign in_ready = rst && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    // Only windows lying fully inside the image are emitted.
    assign qualify  = (row >= RW'(2)) && (col >= CW'(KW - 1));

    cae_line_mem #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_WIDTH),
        .AW    (CW)
    ) lb1 (
        .clk_i   (clk_i),
        .we      (accept),
        .addr    (col),
        .wr_data (in_data),
        .rd_data (lb1_rd)
    );

    cae_line_mem #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_WIDTH),
        .AW    (CW)
    ) lb2 (
        .clk_i   (clk_i),
        .we      (accept),
        .addr    (col),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    // Shift left one column; the new column enters at KW-1.
    always_comb begin
        sr_next = sr;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < KW - 1; k++) begin
                sr_next[r][k] = sr[r][k+1];
            end
        end
        sr_next[0][KW-1] = lb2_rd;
        sr_next[1][KW-1] = lb1_rd;
        sr_next[2][KW-1] = in_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            sr         <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                sr <= sr_next;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                // A non-qualifying accept implies any held window
                // was consumed this cycle, so clearing is safe.
                if (qualify) begin
                    win       <= sr_next;
                    win_valid <= 1'b1;
                end else begin
                    win_valid <= 1'b0;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cae_line_buffer.sv
// Self-checking bench for cae_line_buffer (IMG_W=5, IMG_H=4, KW=3).
// Image-array reference model plus literal window expectations.
module tb_cae_line_buffer;

    typedef logic [2:0][2:0][7:0] win_t;

    logic       clk_i = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       win_valid;
    logic       win_ready = 1'b0;
    win_t       win;
    logic       frame_done;

    always #5 clk_i = ~clk_i;

    cae_line_buffer #(
        .DATA_WIDTH (8),
        .KW         (3),
        .IMG_W      (5),
        .IMG_H      (4)
    ) dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win        (win),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input bit ok,
                         input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window whose top-left pixel value is b (pixel = 5r+c+1).
    function automatic win_t mkw(input int b);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[r][k] = 8'(b + 5 * r + k);
        return w;
    endfunction

    // Reference model: the image as a 2-D array, windows cut from it.
    int         mr = 0;
    int         mc = 0;
    logic [7:0] pix [4][5];
    bit         exp_v = 0;
    bit         exp_fd = 0;
    win_t       exp_w = '0;
    win_t       got_q [$];
    int         fd_cnt = 0;

    always begin : model
        bit         s_acc, s_rst, s_wr, s_v, s_fd;
        logic [7:0] s_d;
        win_t       s_w;
        @(negedge clk_i);
        #4;
        s_acc = in_valid && in_ready;
        s_rst = rst;
        s_wr  = win_ready;
        s_v   = win_valid;
        s_fd  = frame_done;
        s_d   = in_data;
        s_w   = win;
        if (s_rst && s_v && s_wr) got_q.push_back(s_w);
        if (s_rst && s_fd) fd_cnt++;
        @(posedge clk_i);
        #1;
        if (!s_rst) begin
            mr = 0; mc = 0;
            exp_v = 0; exp_fd = 0;
        end else if (s_acc) begin
            pix[mr][mc] = s_d;
            exp_fd = (mr == 3 && mc == 4);
            exp_v  = (mr >= 2 && mc >= 2);
            if (exp_v)
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        exp_w[r][k] = pix[mr-2+r][mc-2+k];
            mc++;
            if (mc == 5) begin
                mc = 0;
                mr = (mr == 3) ? 0 : mr + 1;
            end
        end else begin
            exp_fd = 0;
            if (s_wr) exp_v = 0;
        end
        check("win_valid", win_valid === exp_v, 72'(win_valid), 72'(exp_v));
        check("frame_done", frame_done === exp_fd, 72'(frame_done), 72'(exp_fd));
        check("in_ready", in_ready === (rst && (!exp_v || win_ready)),
              72'(in_ready), 72'(rst && (!exp_v || win_ready)));
        if (exp_v) check("win", win === exp_w, 72'(win), 72'(exp_w));
        if (!s_rst) check("win_reset", win === '0, 72'(win), 72'(0));
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst = 0; in_valid = 0; win_ready = 1;
        @(negedge clk_i);
        rst = 1;
        got_q.delete();
        fd_cnt = 0;
    endtask

    task automatic run_frame(input bit gap, input int stall, input int rst_at);
        int p = 0;
        int budget = 0;
        bit tog = 1;
        bit did = 0;
        int sl = stall;
        bit stalling = 0;
        bit took;
        while (p < 20 && budget < 400) begin
            @(negedge clk_i);
            budget++;
            if (p == rst_at && !did) begin
                did = 1; rst = 0; in_valid = 1;
                in_data = 8'(p + 1); win_ready = 1; p = 0;
                @(posedge clk_i);
                continue;
            end
            rst = 1;
            in_valid = gap ? tog : 1'b1;
            tog = !tog;
            in_data = 8'(p + 1);
            if (sl > 0 && (win_valid || stalling)) begin
                stalling = 1; sl--; win_ready = 0;
                #1;
                check("stall_in_ready", in_ready == 0, 72'(in_ready), 72'(0));
                check("stall_win", win === mkw(1), 72'(win), 72'(mkw(1)));
            end else begin
                win_ready = 1;
            end
            #3;
            took = in_valid && in_ready;
            @(posedge clk_i);
            if (took) p++;
        end
        check("frame_budget", p == 20, 72'(p), 72'(20));
        @(negedge clk_i);
        rst = 1; in_valid = 0; win_ready = 1;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_seq(input string name);
        int bases [6] = '{1, 2, 3, 6, 7, 8};
        check({name, "_count"}, got_q.size() == 6, 72'(got_q.size()), 72'(6));
        for (int i = 0; i < 6; i++)
            if (i < got_q.size())
                check({name, "_win"}, got_q[i] === mkw(bases[i]),
                      72'(got_q[i]), 72'(mkw(bases[i])));
    endtask

    initial begin
        rst = 0;
        repeat (3) @(negedge clk_i);

        do_reset();
        run_frame(0, 0, -1);
        check_seq("full");
        check("full_fd", fd_cnt == 1, 72'(fd_cnt), 72'(1));

        do_reset();
        run_frame(0, 4, -1);
        check_seq("bp");
        check("bp_fd", fd_cnt == 1, 72'(fd_cnt), 72'(1));

        do_reset();
        run_frame(0, 0, 13);
        check("rst_count", got_q.size() == 6, 72'(got_q.size()), 72'(6));
        if (got_q.size() > 0)
            check("rst_first", got_q[0] === mkw(1), 72'(got_q[0]), 72'(mkw(1)));

        do_reset();
        run_frame(1, 0, -1);
        check_seq("gap");
        check("gap_fd", fd_cnt == 1, 72'(fd_cnt), 72'(1));

        do_reset();
        repeat (3000) begin
            @(negedge clk_i);
            rst       = ($urandom_range(0, 199) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            win_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
        end
        @(negedge clk_i);
        rst = 1; in_valid = 0; win_ready = 1;
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
